// File: rtl/stack_pkg.sv
// Shared definitions for the stack_param block.
// Holds the command encoding carried on the COMMAND port and its width.
package stack_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP  = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2,
    CMD_GET  = 2'd3
  } cmd_e;

endpackage

// File: rtl/stack_regfile.sv
// Storage array for stack_param: DEPTH entries of DATA_W bits.
// Ports:
//   clk_i   - clock, writes take effect on the rising edge
//   rst_i   - asynchronous active-high clear of every entry
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - combinational read address
//   rdata_o - combinational read data (0 for addresses beyond the array)
module stack_regfile #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [IDX_W-1:0] LastAddr = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Guard against out-of-array addresses when DEPTH is not a power of two.
  assign rdata_o = (raddr_i <= LastAddr) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/stack_param.sv
// Parameterised LIFO stack with indexed peek, built on a ring of DEPTH entries.
// Ports:
//   CLK     - clock, all state changes on the rising edge
//   RESET   - asynchronous active-high reset
//   COMMAND - 0 NOP, 1 PUSH, 2 POP, 3 GET
//   INDEX   - GET depth below top (0 = top)
//   I_DATA  - PUSH data
//   O_DATA  - registered result of the last accepted PUSH/POP/GET
//   O_VALID - O_DATA was updated by the last command
//   COUNT   - current occupancy 0..DEPTH
//   FULL    - COUNT == DEPTH
//   EMPTY   - COUNT == 0
//   ERROR   - one-cycle pulse when the last command was rejected
module stack_param
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned WRAP   = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [CMD_W-1:0]           COMMAND,
  input  logic [$clog2(DEPTH)-1:0]   INDEX,
  input  logic [DATA_W-1:0]          I_DATA,
  output logic [DATA_W-1:0]          O_DATA,
  output logic                       O_VALID,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ERROR
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DepthW  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   DepthM1 = (IDX_W + 1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);
  localparam bit               WrapEn  = (WRAP != 0);

  cmd_e cmd;
  assign cmd = cmd_e'(COMMAND);

  logic [IDX_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              o_valid_q, o_valid_d;
  logic              error_q, error_d;

  logic              full, empty;
  logic [IDX_W-1:0]  tp_inc, tp_dec;
  logic [IDX_W-1:0]  rd_off;
  logic [IDX_W:0]    rd_sum, rd_wrap;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              get_ok;
  logic              we;

  assign full  = (cnt_q == DepthC);
  assign empty = (cnt_q == '0);

  assign tp_inc = (tp_q == LastIdx) ? '0 : tp_q + IDX_W'(1);
  assign tp_dec = (tp_q == '0) ? LastIdx : tp_q - IDX_W'(1);

  // Read slot = (TP - 1 - off) mod DEPTH. Biasing by DEPTH-1 keeps the sum
  // non-negative for every in-range offset, so one conditional subtract
  // finishes the modulo. Out-of-range GETs never use the result.
  assign rd_off  = (cmd == CMD_GET) ? INDEX : '0;
  assign rd_sum  = {1'b0, tp_q} + DepthM1 - {1'b0, rd_off};
  assign rd_wrap = (rd_sum >= DepthW) ? rd_sum - DepthW : rd_sum;
  assign rd_addr = rd_wrap[IDX_W-1:0];

  // No modulo on INDEX: anything at or beyond the occupancy is rejected.
  assign get_ok = (CNT_W'(INDEX) < cnt_q);

  stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (we),
    .waddr_i (tp_q),
    .wdata_i (I_DATA),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    error_d   = 1'b0;
    we        = 1'b0;
    unique case (cmd)
      CMD_PUSH: begin
        if (!full || WrapEn) begin
          // On a wrapping full push TP already points at the oldest entry.
          we        = 1'b1;
          tp_d      = tp_inc;
          o_data_d  = I_DATA;
          o_valid_d = 1'b1;
          if (!full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          error_d = 1'b1;
        end
      end
      CMD_POP: begin
        if (!empty) begin
          tp_d      = tp_dec;
          cnt_d     = cnt_q - CNT_W'(1);
          o_data_d  = rd_data;
          o_valid_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      CMD_GET: begin
        if (get_ok) begin
          o_data_d  = rd_data;
          o_valid_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tp_q      <= '0;
      cnt_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      tp_q      <= tp_d;
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      error_q   <= error_d;
    end
  end

  assign O_DATA  = o_data_q;
  assign O_VALID = o_valid_q;
  assign ERROR   = error_q;
  assign COUNT   = cnt_q;
  assign FULL    = full;
  assign EMPTY   = empty;

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: one instance with WRAP=0 and one with WRAP=1.
// Directed commands push their hand-computed response into a per-instance
// queue; monitors pop and compare whenever an instance raises O_VALID/ERROR.
module tb_stack_param;
  import stack_pkg::*;

  localparam int DW = 4;
  localparam int DP = 5;
  localparam int IW = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cmd0, cmd1;
  logic [IW-1:0] idx0, idx1;
  logic [DW-1:0] din0, din1;
  logic [DW-1:0] od0, od1;
  logic          ov0, ov1, err0, err1, full0, full1, empty0, empty1;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  stack_param #(.DATA_W(DW), .DEPTH(DP), .WRAP(0)) u_dut0 (
    .CLK(clk), .RESET(rst), .COMMAND(cmd0), .INDEX(idx0), .I_DATA(din0),
    .O_DATA(od0), .O_VALID(ov0), .COUNT(cnt0), .FULL(full0), .EMPTY(empty0), .ERROR(err0)
  );

  stack_param #(.DATA_W(DW), .DEPTH(DP), .WRAP(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .COMMAND(cmd1), .INDEX(idx1), .I_DATA(din1),
    .O_DATA(od1), .O_VALID(ov1), .COUNT(cnt1), .FULL(full1), .EMPTY(empty1), .ERROR(err1)
  );

  typedef struct packed {
    logic          v;
    logic          e;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // {valid, error, data, count, full, empty}
  function automatic logic [31:0] pk(input logic v, input logic e, input logic [DW-1:0] d,
                                     input logic [CW-1:0] c, input logic f, input logic em);
    return {21'b0, v, e, d, c, f, em};
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (ov0 || err0) begin
      if (q0.size() == 0) begin
        check("dut0_spurious", pk(ov0, err0, od0, cnt0, full0, empty0), 32'd0);
      end else begin
        x = q0.pop_front();
        check("dut0_resp", pk(ov0, err0, od0, cnt0, full0, empty0),
              pk(x.v, x.e, x.d, x.c, x.c == CW'(DP), x.c == '0));
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (ov1 || err1) begin
      if (q1.size() == 0) begin
        check("dut1_spurious", pk(ov1, err1, od1, cnt1, full1, empty1), 32'd0);
      end else begin
        x = q1.pop_front();
        check("dut1_resp", pk(ov1, err1, od1, cnt1, full1, empty1),
              pk(x.v, x.e, x.d, x.c, x.c == CW'(DP), x.c == '0));
      end
    end
  end

  // Drive one command on the selected instance (other gets NOP) for one cycle.
  task automatic issue(input int dut, input logic [1:0] c, input logic [IW-1:0] i,
                       input logic [DW-1:0] d, input logic ev, input logic ee,
                       input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    exp_t x;
    x = '{v: ev, e: ee, d: ed, c: ec};
    cmd0 = CMD_NOP; cmd1 = CMD_NOP;
    if (dut == 0) begin
      cmd0 = c; idx0 = i; din0 = d; q0.push_back(x);
    end else begin
      cmd1 = c; idx1 = i; din1 = d; q1.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic ok(input int dut, input logic [1:0] c, input logic [IW-1:0] i,
                    input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    issue(dut, c, i, d, 1'b1, 1'b0, ed, ec);
  endtask

  task automatic bad(input int dut, input logic [1:0] c, input logic [IW-1:0] i,
                     input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    issue(dut, c, i, '0, 1'b0, 1'b1, ed, ec);
  endtask

  task automatic nop();
    cmd0 = CMD_NOP; cmd1 = CMD_NOP;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd0 = CMD_NOP; cmd1 = CMD_NOP;
    idx0 = '0; idx1 = '0; din0 = '0; din1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state0", pk(ov0, err0, od0, cnt0, full0, empty0), pk(0, 0, 0, 0, 0, 1));
    check("reset_state1", pk(ov1, err1, od1, cnt1, full1, empty1), pk(0, 0, 0, 0, 0, 1));

    // push 3,7,9 then pop
    ok(0, CMD_PUSH, 0, 4'd3, 4'd3, 3'd1);
    ok(0, CMD_PUSH, 0, 4'd7, 4'd7, 3'd2);
    ok(0, CMD_PUSH, 0, 4'd9, 4'd9, 3'd3);
    ok(0, CMD_POP,  0, 4'd0, 4'd9, 3'd2);
    nop();
    check("nop_holds", pk(ov0, err0, od0, cnt0, full0, empty0), pk(0, 0, 4'd9, 3'd2, 0, 0));

    // GET at/below occupancy with COUNT=2
    bad(0, CMD_GET, 3'd2, 4'd9, 3'd2);
    ok(0, CMD_GET, 3'd1, 4'd0, 4'd3, 3'd2);
    ok(0, CMD_GET, 3'd0, 4'd0, 4'd7, 3'd2);
    ok(0, CMD_POP, 0, 4'd0, 4'd7, 3'd1);
    ok(0, CMD_POP, 0, 4'd0, 4'd3, 3'd0);
    bad(0, CMD_POP, 0, 4'd3, 3'd0);
    bad(0, CMD_GET, 3'd0, 4'd3, 3'd0);

    // fill, peek both ends, reject overflow
    for (int k = 1; k <= 5; k++) ok(0, CMD_PUSH, 0, 4'(k), 4'(k), 3'(k));
    ok(0, CMD_GET, 3'd4, 4'd0, 4'd1, 3'd5);
    ok(0, CMD_GET, 3'd0, 4'd0, 4'd5, 3'd5);
    bad(0, CMD_PUSH, 0, 4'd5, 3'd5);
    nop();
    check("error_one_cycle", {31'b0, err0}, 32'd0);
    ok(0, CMD_POP, 0, 4'd0, 4'd5, 3'd4);
    bad(0, CMD_GET, 3'd4, 4'd5, 3'd4);
    bad(0, CMD_GET, 3'd7, 4'd5, 3'd4);
    ok(0, CMD_POP, 0, 4'd0, 4'd4, 3'd3);

    // asynchronous reset in mid-cycle, aborting a pending push
    cmd0 = CMD_PUSH; din0 = 4'hF;
    #2 rst = 1'b1;
    #1;
    check("async_reset", pk(ov0, err0, od0, cnt0, full0, empty0), pk(0, 0, 0, 0, 0, 1));
    @(negedge clk);
    cmd0 = CMD_NOP;
    rst = 1'b0;
    bad(0, CMD_POP, 0, 4'd0, 3'd0);
    ok(0, CMD_PUSH, 0, 4'd8, 4'd8, 3'd1);

    // wrapping instance: overwrite oldest on full push
    for (int k = 1; k <= 5; k++) ok(1, CMD_PUSH, 0, 4'(k), 4'(k), 3'(k));
    ok(1, CMD_PUSH, 0, 4'd6, 4'd6, 3'd5);
    ok(1, CMD_GET, 3'd4, 4'd0, 4'd2, 3'd5);
    for (int k = 0; k < 5; k++) ok(1, CMD_POP, 0, 4'd0, 4'(6 - k), 3'(4 - k));
    check("wrap_empty", {31'b0, empty1}, 32'd1);
    bad(1, CMD_POP, 0, 4'd2, 3'd0);

    nop();
    nop();
    check("dut0_drain", q0.size(), 32'd0);
    check("dut1_drain", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
